scope_trace_render: RTL and testbench
=====================================

# scope_trace_render

Pixel-colour source for the 1280x1024 @ 108 MHz VGA output stage. Captures a triggered run of 8-bit ADC samples into a ping-pong line buffer, swaps buffers only at frame boundaries, and, for each pixel coordinate the timing stage presents, returns the RGB value of a scope display: graticule plus one-sample-per-column trace. Sits directly upstream of the VGA timing/output stage and downstream of the ADC sample interface.

## Interface
Parameters:
- H_ACTIVE, 1280, visible columns
- V_ACTIVE, 1024, visible rows
- DEPTH, 1280, samples per capture (one per column, DEPTH <= H_ACTIVE)
- GRID, 128, graticule spacing in pixels (power of two)

Ports:
- clock  in  1  108 MHz pixel clock, all logic on posedge
- reset_n  in  1  asynchronous, active-low reset
- sample_valid  in  1  sample_data qualifier
- sample_data  in  8  unsigned ADC sample
- trig_level  in  8  trigger threshold
- trig_rising  in  1  1 = rising-edge trigger, 0 = falling
- force_trig  in  1  one-cycle pulse: trigger on next valid sample
- frame_start  in  1  one-cycle pulse at start of vertical sync
- pix_valid  in  1  current pixel in display interval
- pix_x  in  11  current column
- pix_y  in  11  current row
- colour_R, colour_G, colour_B  out  8 each  pixel colour
- armed  out  1  high in WAIT_TRIG
- capture_ready  out  1  high in READY

## Operation
- FSM states: WAIT_TRIG, CAPTURE, READY. Reset -> WAIT_TRIG.
- WAIT_TRIG: holds prev sample. First valid sample after entry only loads prev (no compare). Rising trigger: prev < trig_level && cur >= trig_level. Falling: prev > trig_level && cur <= trig_level. force_trig latches a pending flag; next valid sample triggers regardless of level. On trigger: triggering sample written to back-buffer index 0, wr_idx <= 1, -> CAPTURE.
- CAPTURE: each valid sample written at wr_idx, wr_idx increments. Write of index DEPTH-1 -> READY. Invalid cycles: no write, no advance.
- READY: samples ignored. On frame_start: front bank select toggles, front_valid <= 1, pending force cleared, -> WAIT_TRIG (prev invalidated).
- frame_start in WAIT_TRIG/CAPTURE: no swap, front buffer unchanged, capture continues.
- Capture completing in the same cycle as frame_start: swap deferred to next frame_start.
- Render, per pixel: trace row = 255 - sample; trace lit when pix_x < DEPTH and pix_y[9:2] == 255 - front[pix_x] (4-row-thick trace). Grid lit when pix_x mod GRID == 0 or pix_y mod GRID == 0, or pix_x == H_ACTIVE-1, or pix_y == V_ACTIVE-1.
- Priority: !pix_valid or !front_valid -> (0,0,0); trace -> (0,255,0); grid -> (64,64,64); else (0,0,0).
- pix_x >= DEPTH: no trace, grid only.

## Timing
- Reset: colour_R/G/B = 0, armed = 1, capture_ready = 0, front bank = 0, front_valid = 0, wr_idx = 0. Asserting reset_n low mid-capture aborts it immediately; RAM contents not cleared and not displayed until next swap.
- Render latency: exactly 2 cycles from pix_x/pix_y/pix_valid to colour (cycle 1: sync RAM read + coordinate/valid pipeline register; cycle 2: registered colour). Downstream compensates by 2 cycles.
- Sample write: RAM written on the clock edge sampling sample_valid; trigger decision and first write on the same edge.
- armed/capture_ready are registered state decodes, updated on the edge that changes state.
- Read and write banks are always different; no read/write collision possible.

## Structure
- Package scope_pkg: H_ACTIVE, V_ACTIVE, GRID defaults; colour constants (TRACE, GRID, BLACK as 24-bit RGB); state enum.
- Sub-module scope_sample_ram: simple dual-port, 2*DEPTH x 8, address = {bank, index}, one write port, one synchronous read port, no reset.

## Test plan
- Rising trigger: level 128, ramp 0..255 repeating, then frame_start -> trigger at sample 128, front[0]=128, front[k]=(128+k) mod 256; pixel (0, 508..511) green, (0, 507) grey (x=0 gridline), (1, 508) black.
- Falling trigger: trig_rising=0, level 100, square 200/0 -> first captured sample 0; capture_ready rises exactly after DEPTH valid samples with sample_valid toggling every other cycle.
- force_trig with constant 50 input -> capture starts on next valid sample; all trace rows 820..823 lit in every column.
- frame_start pulses while in CAPTURE -> output unchanged (black before first swap, front_valid=0); swap on first frame_start after capture_ready.
- Capture completes on same cycle as frame_start -> no swap that frame; swap at next pulse.
- reset_n low mid-CAPTURE -> colours 0 and armed=1 asynchronously; pix_valid=0 always black; 2-cycle latency checked on a single-pixel pix_valid pulse.

Source files
------------

// File: rtl/scope_trace_render_pkg.sv
// Shared constants, colours and FSM state type
// for the scope trace renderer.
package scope_pkg;

  localparam int DEF_H_ACTIVE = 1280;
  localparam int DEF_V_ACTIVE = 1024;
  localparam int DEF_GRID     = 128;

  localparam logic [23:0] TRACE_RGB = 24'h00FF00;
  localparam logic [23:0] GRID_RGB  = 24'h404040;
  localparam logic [23:0] BLACK_RGB = 24'h000000;

  typedef enum logic [1:0] {
    WAIT_TRIG = 2'd0,
    CAPTURE   = 2'd1,
    READY     = 2'd2
  } st_e;

endpackage

// File: rtl/scope_trace_render_if.sv
// Sample, trigger, pixel and colour bundle
// between the ADC/timing side and the renderer.
interface scope_trace_render_if;

  logic        sample_valid;
  logic [7:0]  sample_data;
  logic [7:0]  trig_level;
  logic        trig_rising;
  logic        force_trig;
  logic        frame_start;
  logic        pix_valid;
  logic [10:0] pix_x;
  logic [10:0] pix_y;
  logic [7:0]  colour_R;
  logic [7:0]  colour_G;
  logic [7:0]  colour_B;
  logic        armed;
  logic        capture_ready;

  modport master (
    output sample_valid, sample_data,
    output trig_level, trig_rising,
    output force_trig, frame_start,
    output pix_valid, pix_x, pix_y,
    input  colour_R, colour_G, colour_B,
    input  armed, capture_ready
  );

  modport slave (
    input  sample_valid, sample_data,
    input  trig_level, trig_rising,
    input  force_trig, frame_start,
    input  pix_valid, pix_x, pix_y,
    output colour_R, colour_G, colour_B,
    output armed, capture_ready
  );

endinterface

// File: rtl/scope_trace_render_ram.sv
// Ping-pong sample store: address = {bank, index},
// one write port, one registered read port.
module scope_sample_ram #(
  parameter int AW = 11
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW:0]   waddr,
  input  logic [7:0]    wdata,
  input  logic [AW:0]   raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [2**(AW+1)];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/scope_trace_render.sv
// Triggered capture into a ping-pong buffer plus
// a two-cycle graticule/trace pixel renderer.
module scope_trace_render
  import scope_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int DEPTH    = DEF_H_ACTIVE,
  parameter int GRID     = DEF_GRID
) (
  input  logic clock,
  input  logic reset_n,
  scope_trace_render_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int GB = $clog2(GRID);
  localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);
  localparam logic [10:0]   X_END = 11'(DEPTH);
  localparam logic [10:0]   X_MAX = 11'(H_ACTIVE - 1);
  localparam logic [10:0]   Y_MAX = 11'(V_ACTIVE - 1);

  st_e           state, state_n;
  logic [7:0]    prev;
  logic          prev_ok;
  logic          force_pend;
  logic [AW-1:0] wr_idx;
  logic          front_bank;
  logic          front_valid;
  logic          armed_q, ready_q;
  logic          lvl_hit, trig_hit;
  logic          we;
  logic [AW:0]   waddr;
  logic [7:0]    rd;

  always_comb begin
    if (bus.trig_rising)
      lvl_hit = prev < bus.trig_level &&
                bus.sample_data >= bus.trig_level;
    else
      lvl_hit = prev > bus.trig_level &&
                bus.sample_data <= bus.trig_level;
    trig_hit = state == WAIT_TRIG && bus.sample_valid &&
               (force_pend || (prev_ok && lvl_hit));
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= WAIT_TRIG;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      WAIT_TRIG: if (trig_hit) state_n = CAPTURE;
      CAPTURE:
        if (bus.sample_valid && wr_idx == LAST)
          state_n = READY;
      READY: if (bus.frame_start) state_n = WAIT_TRIG;
      default: state_n = WAIT_TRIG;
    endcase
  end

  // Captures always land in the bank not being displayed.
  always_comb begin
    we    = 1'b0;
    waddr = {~front_bank, wr_idx};
    unique case (state)
      WAIT_TRIG: begin
        we    = trig_hit;
        waddr = {~front_bank, {AW{1'b0}}};
      end
      CAPTURE: we = bus.sample_valid;
      default: we = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev        <= '0;
      prev_ok     <= 1'b0;
      force_pend  <= 1'b0;
      wr_idx      <= '0;
      front_bank  <= 1'b0;
      front_valid <= 1'b0;
      armed_q     <= 1'b1;
      ready_q     <= 1'b0;
    end else begin
      armed_q <= state_n == WAIT_TRIG;
      ready_q <= state_n == READY;
      if (bus.force_trig) force_pend <= 1'b1;
      unique case (state)
        WAIT_TRIG: begin
          if (bus.sample_valid) begin
            prev    <= bus.sample_data;
            prev_ok <= 1'b1;
          end
          if (trig_hit) begin
            wr_idx     <= AW'(1);
            force_pend <= 1'b0;
          end
        end
        CAPTURE:
          if (bus.sample_valid) wr_idx <= wr_idx + 1'b1;
        READY:
          if (bus.frame_start) begin
            front_bank  <= ~front_bank;
            front_valid <= 1'b1;
            force_pend  <= 1'b0;
            prev_ok     <= 1'b0;
          end
        default: ;
      endcase
    end
  end

  scope_sample_ram #(.AW(AW)) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (waddr),
    .wdata (bus.sample_data),
    .raddr ({front_bank, bus.pix_x[AW-1:0]}),
    .rdata (rd)
  );

  logic        vld1, fv1;
  logic [10:0] x1, y1;
  logic        trace_on, grid_on;
  logic [23:0] rgb_n, rgb_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld1 <= 1'b0;
      fv1  <= 1'b0;
      x1   <= '0;
      y1   <= '0;
    end else begin
      vld1 <= bus.pix_valid;
      fv1  <= front_valid;
      x1   <= bus.pix_x;
      y1   <= bus.pix_y;
    end
  end

  // Row of a sample is 255 - s, i.e. ~s; 4 lines per row.
  always_comb begin
    trace_on = x1 < X_END && y1[9:2] == ~rd;
    grid_on  = x1[GB-1:0] == '0 || y1[GB-1:0] == '0 ||
               x1 == X_MAX || y1 == Y_MAX;
    if (!vld1 || !fv1) rgb_n = BLACK_RGB;
    else if (trace_on) rgb_n = TRACE_RGB;
    else if (grid_on)  rgb_n = GRID_RGB;
    else               rgb_n = BLACK_RGB;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rgb_q <= BLACK_RGB;
    else          rgb_q <= rgb_n;
  end

  assign bus.colour_R      = rgb_q[23:16];
  assign bus.colour_G      = rgb_q[15:8];
  assign bus.colour_B      = rgb_q[7:0];
  assign bus.armed         = armed_q;
  assign bus.capture_ready = ready_q;

endmodule

// File: tb/tb_scope_trace_render.sv
// Directed bench for scope_trace_render: triggers,
// buffer swaps, render colours, latency and reset.
module tb_scope_trace_render;

  localparam int DEPTH = 1280;
  localparam logic [23:0] GRN = 24'h00FF00;
  localparam logic [23:0] GRY = 24'h404040;
  localparam logic [23:0] BLK = 24'h000000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_run = 0;
  int   n_fail = 0;
  logic [23:0] rgb;

  scope_trace_render_if bus ();

  scope_trace_render u_dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] col();
    return {bus.colour_R, bus.colour_G, bus.colour_B};
  endfunction

  task automatic probe(input int x, input int y,
                       output logic [23:0] c);
    @(negedge clock);
    bus.pix_valid = 1'b1;
    bus.pix_x = 11'(x);
    bus.pix_y = 11'(y);
    @(negedge clock);
    bus.pix_valid = 1'b0;
    @(negedge clock);
    c = col();
  endtask

  task automatic px(input string tag, input int x,
                    input int y, input logic [23:0] e);
    logic [23:0] c;
    probe(x, y, c);
    chk(tag, 32'(c), 32'(e));
  endtask

  task automatic smp(input logic v, input logic [7:0] d);
    @(negedge clock);
    bus.sample_valid = v;
    bus.sample_data  = d;
  endtask

  task automatic frame_pulse();
    @(negedge clock);
    bus.frame_start = 1'b1;
    @(negedge clock);
    bus.frame_start = 1'b0;
  endtask

  task automatic force_pulse();
    @(negedge clock);
    bus.force_trig = 1'b1;
    @(negedge clock);
    bus.force_trig = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    bus.trig_level   = 8'd128;
    bus.trig_rising  = 1'b1;
    bus.force_trig   = 1'b0;
    bus.frame_start  = 1'b0;
    bus.pix_valid    = 1'b0;
    bus.pix_x        = '0;
    bus.pix_y        = '0;
    repeat (3) @(negedge clock);
    chk("rst_rgb", 32'(col()), 32'(BLK));
    chk("rst_armed", 32'(bus.armed), 32'd1);
    chk("rst_ready", 32'(bus.capture_ready), 32'd0);
    reset_n = 1'b1;

    px("nofront", 0, 0, BLK);

    // rising ramp, paused mid-capture
    for (int i = 0; i < 200; i++) smp(1'b1, 8'(i));
    smp(1'b0, 8'd0);
    chk("cap_armed", 32'(bus.armed), 32'd0);
    px("cap_black", 0, 0, BLK);
    frame_pulse();
    px("cap_fs_black", 0, 508, BLK);
    chk("cap_fs_ready", 32'(bus.capture_ready), 32'd0);
    for (int i = 200; i < 3000 && !bus.capture_ready; i++)
      smp(1'b1, 8'(i));
    smp(1'b0, 8'd0);
    chk("rise_ready", 32'(bus.capture_ready), 32'd1);
    chk("rise_armed", 32'(bus.armed), 32'd0);
    frame_pulse();
    chk("swap_armed", 32'(bus.armed), 32'd1);
    chk("swap_ready", 32'(bus.capture_ready), 32'd0);
    px("r_0_508", 0, 508, GRN);
    px("r_0_511", 0, 511, GRN);
    px("r_0_507", 0, 507, GRY);
    px("r_1_508", 1, 508, BLK);
    px("r_10_468", 10, 468, GRN);
    px("r_1279_513", 1279, 513, GRN);
    px("r_640_640", 640, 640, GRY);
    px("r_641_641", 641, 641, BLK);

    // falling square, valid every other cycle
    bus.trig_rising = 1'b0;
    bus.trig_level  = 8'd100;
    for (int n = 0; n <= DEPTH; n++) begin
      @(negedge clock);
      bus.sample_valid = 1'b1;
      bus.sample_data  = (n % 2 == 0) ? 8'd200 : 8'd0;
      @(negedge clock);
      bus.sample_valid = 1'b0;
      if (n == DEPTH - 1)
        chk("fall_ready_early", 32'(bus.capture_ready), 32'd0);
      if (n == DEPTH)
        chk("fall_ready", 32'(bus.capture_ready), 32'd1);
    end
    px("fall_preswap", 0, 508, GRN);
    frame_pulse();
    px("f_0_1021", 0, 1021, GRN);
    px("f_2_1021", 2, 1021, GRN);
    px("f_1_221", 1, 221, GRN);
    px("f_1_1021", 1, 1021, BLK);

    // forced trigger, constant 50
    force_pulse();
    for (int n = 0; n < DEPTH; n++) smp(1'b1, 8'd50);
    smp(1'b0, 8'd0);
    chk("frc_ready", 32'(bus.capture_ready), 32'd1);
    px("frc_preswap", 1, 221, GRN);
    frame_pulse();
    px("k_5_820", 5, 820, GRN);
    px("k_5_823", 5, 823, GRN);
    px("k_5_824", 5, 824, BLK);
    px("k_1279_821", 1279, 821, GRN);
    px("k_1279_819", 1279, 819, GRY);
    px("k_700_1023", 700, 1023, GRY);

    // capture ends on the frame_start cycle
    force_pulse();
    for (int n = 0; n < DEPTH; n++) begin
      @(negedge clock);
      bus.sample_valid = 1'b1;
      bus.sample_data  = 8'd10;
      bus.frame_start  = (n == DEPTH - 1);
    end
    @(negedge clock);
    bus.sample_valid = 1'b0;
    bus.frame_start  = 1'b0;
    chk("same_ready", 32'(bus.capture_ready), 32'd1);
    px("same_noswap", 5, 821, GRN);
    frame_pulse();
    px("same_swap_new", 5, 981, GRN);
    px("same_swap_old", 5, 821, BLK);

    // two-cycle latency on a single pixel pulse
    @(negedge clock);
    bus.pix_valid = 1'b1;
    bus.pix_x = 11'd0;
    bus.pix_y = 11'd0;
    @(negedge clock);
    bus.pix_valid = 1'b0;
    chk("lat_c1", 32'(col()), 32'(BLK));
    @(negedge clock);
    chk("lat_c2", 32'(col()), 32'(GRY));
    @(negedge clock);
    chk("lat_c3_invalid", 32'(col()), 32'(BLK));

    // asynchronous reset mid-capture
    force_pulse();
    for (int n = 0; n < 100; n++) smp(1'b1, 8'd77);
    @(negedge clock);
    bus.sample_valid = 1'b0;
    bus.pix_valid = 1'b1;
    @(negedge clock);
    @(negedge clock);
    chk("pre_rst_rgb", 32'(col()), 32'(GRY));
    chk("pre_rst_armed", 32'(bus.armed), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_rgb", 32'(col()), 32'(BLK));
    chk("arst_armed", 32'(bus.armed), 32'd1);
    chk("arst_ready", 32'(bus.capture_ready), 32'd0);
    @(negedge clock);
    bus.pix_valid = 1'b0;
    reset_n = 1'b1;
    px("post_rst_black", 0, 0, BLK);
    px("post_rst_trace", 5, 981, BLK);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
